butterfly_loader: RTL and testbench
===================================

BUTTERFLY_LOADER -- requirements
Module: butterfly_loader

Interface
REQ-001 The block SHALL expose these ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  one complex word per beat: [15:0] real, [31:16] imag.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts a beat this cycle.
- data_par_out  out  48x16  packed frame, same layout as the ButterflyWrapper data_par_in bus.
- out_valid  out  1  data_par_out holds a complete frame.
- out_ready  in  1  consumer takes the frame this cycle.
- frame_cnt  out  8  count of frames delivered.
- flush  in  1  present only when BUTTERFLY_LOADER_FLUSH_EN is defined (REQ-016).
REQ-002 The block SHALL have no parameters; the frame size is fixed at 8 butterflies x 3 beats = 24 beats.

Function
REQ-003 A beat SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-004 The mapping SHALL be: accepted beat k (0..23), butterfly b=k/3, slot s=k%3 (0=sample A, 1=sample B, 2=twiddle).
- in_data[15:0] -> word 6b+2s.
- in_data[31:16] -> word 6b+2s+1.
REQ-005 The FSM SHALL have three states: IDLE (beat_cnt=0), FILL (beat_cnt 1..23) and FULL.
REQ-006 The transitions SHALL be:
- IDLE -> FILL on an accepted beat.
- FILL -> FILL on an accepted beat with beat_cnt<23.
- FILL -> FULL on accepting beat 23.
- FULL -> IDLE on out_valid & out_ready.
REQ-007 in_ready SHALL be 1 in IDLE and FILL, 0 in FULL, and 0 while rst=1.
REQ-008 out_valid SHALL be 1 exactly while in FULL; it is a registered output.
REQ-009 Latency: out_valid SHALL rise on the clock edge that accepts beat 23, so it is visible the cycle after that beat.
REQ-010 data_par_out SHALL be stable while out_valid=1; words not yet written in the current frame retain their previous frame's values.
REQ-011 Handshake release: in the cycle after out_valid & out_ready, out_valid=0 and in_ready=1. Backpressure (out_ready=0) SHALL hold FULL indefinitely.
REQ-012 In FULL, in_valid SHALL be ignored; no beat is accepted, including in the handshake cycle itself.
REQ-013 frame_cnt SHALL increment by 1 on each out_valid & out_ready and wrap 255 -> 0.
REQ-014 in_valid gaps SHALL NOT alter beat_cnt or stored words.

Reset
REQ-015 When rst=1 at a clock edge, the block SHALL:
- set state to IDLE and beat_cnt to 0;
- set out_valid=0 and frame_cnt=0;
- clear all 48 words of data_par_out to 0.
This SHALL apply at any point, including mid-FILL or in FULL, and a partial frame SHALL be discarded.

Configuration
REQ-016 With BUTTERFLY_LOADER_FLUSH_EN defined, the flush port SHALL exist and behave as follows:
- flush=1 in IDLE/FILL: next state IDLE, beat_cnt=0, written words kept; flush has priority over a simultaneous in_valid beat, and that beat is not accepted (in_ready=0 while flush=1).
- flush=1 in FULL: no effect.
REQ-017 Without BUTTERFLY_LOADER_FLUSH_EN, the flush port SHALL be absent and the behaviour SHALL be as REQ-003..015.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Basic frame: after reset, 24 back-to-back beats, beat k = {16'(k*2+1), 16'(k*2)}, out_ready=1 -> out_valid high exactly 1 cycle, beginning the cycle after beat 23; word n = n for n=0..47; frame_cnt=1.
- Twiddle identity: each butterfly gets A=0, B=0, twiddle {0x0000,0x0100} -> words 4,10,...,46 = 0x0100; all other words 0.
- Backpressure: full frame with out_ready=0 for 10 cycles and in_valid held 1 -> in_ready=0 and data_par_out unchanged for all 10 cycles; the extra beat is accepted only after the handshake and becomes word 0/1 of the next frame.
- Mid-frame reset: rst pulsed after beat 11 -> out_valid=0, all words 0, frame_cnt=0; next 24 beats form a correct frame.
- Wrap: 256 frames delivered -> frame_cnt reads 0.
- Flush (FLUSH_EN): flush asserted with in_valid after beat 5 -> beat not accepted; a subsequent 24-beat frame lands at words 0..47 with correct values.

Source files
------------

// File: rtl/butterfly_loader.sv
// Collects 24 complex beats into a 48-word butterfly frame and hands it off with a valid/ready handshake.
// Optional flush port enabled by defining BUTTERFLY_LOADER_FLUSH_EN.
module butterfly_loader (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [47:0][15:0] data_par_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        frame_cnt
`ifdef BUTTERFLY_LOADER_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        beat_q, beat_d;
  logic [47:0][15:0] words_q;
  logic [7:0]        frame_q;
  logic              out_valid_q;
  logic              flush_w;
  logic              accept;
  logic              deliver;
  logic [5:0]        idx_lo, idx_hi;

`ifdef BUTTERFLY_LOADER_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Word 6b+2s collapses to 2k, so beat k always lands in words 2k and 2k+1.
  assign idx_lo = {beat_q, 1'b0};
  assign idx_hi = {beat_q, 1'b1};

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    deliver  = 1'b0;
    case (state_q)
      IDLE, FILL: begin
        in_ready = !rst && !flush_w;
        accept   = in_valid && in_ready;
        if (flush_w) begin
          state_d = IDLE;
          beat_d  = 5'd0;
        end else if (accept) begin
          if (beat_q == 5'd23) begin
            state_d = FULL;
            beat_d  = 5'd0;
          end else begin
            state_d = FILL;
            beat_d  = beat_q + 5'd1;
          end
        end
      end
      FULL: begin
        deliver = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        beat_d  = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= 5'd0;
      words_q     <= '0;
      frame_q     <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      out_valid_q <= (state_d == FULL);
      if (accept) begin
        words_q[idx_lo] <= in_data[15:0];
        words_q[idx_hi] <= in_data[31:16];
      end
      if (deliver) frame_q <= frame_q + 8'd1;
    end
  end

  assign data_par_out = words_q;
  assign out_valid    = out_valid_q;
  assign frame_cnt    = frame_q;

endmodule

// File: tb/tb_butterfly_loader.sv
// Scoreboard bench for butterfly_loader: expected frames queued as beats are driven, checked on handshake.
module tb_butterfly_loader;
  typedef logic [47:0][15:0] frame_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  frame_t      data_par_out;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  frame_cnt;
`ifdef BUTTERFLY_LOADER_FLUSH_EN
  logic        flush;
`endif

  int     checks = 0;
  int     errors = 0;
  frame_t exp_q[$];
  frame_t words_m;
  int     k_m;
  logic [7:0] exp_fc;

  butterfly_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .data_par_out(data_par_out), .out_valid(out_valid), .out_ready(out_ready),
    .frame_cnt(frame_cnt)
`ifdef BUTTERFLY_LOADER_FLUSH_EN
    , .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  // Output side of the scoreboard: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      frame_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got %h, required no frame", data_par_out);
      end else begin
        e = exp_q.pop_front();
        if (data_par_out !== e) begin
          errors++;
          $display("FAIL frame_data: got %h, required %h", data_par_out, e);
        end
        exp_fc = exp_fc + 8'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    words_m = '0;
    k_m = 0;
    exp_fc = 8'd0;
  endtask

  task automatic send_beat(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: in_ready=%b, required 1", in_ready);
      #4;
      in_valid = 1'b0;
      return;
    end
    step();
    words_m[2*k_m]   = d[15:0];
    words_m[2*k_m+1] = d[31:16];
    k_m++;
    if (k_m == 24) begin
      exp_q.push_back(words_m);
      k_m = 0;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hFFFF_FFFF;
    step();
    step();
    checks += 4;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt); end
    if (data_par_out !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", data_par_out); end
    apply_reset();
  endtask

  task automatic test_basic_frame();
    out_ready = 1'b1;
    for (int k = 0; k < 24; k++) send_beat({16'(k*2+1), 16'(k*2)});
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_rise: got %b, required 1", out_valid); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_full: got %b, required 0", in_ready); end
    for (int n = 0; n < 48; n++) begin
      if (data_par_out[n] !== 16'(n)) begin
        errors++;
        $display("FAIL basic_word%0d: got %h, required %h", n, data_par_out[n], 16'(n));
        break;
      end
    end
    step();
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_fall: got %b, required 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_release: got %b, required 1", in_ready); end
    if (frame_cnt !== 8'd1) begin errors++; $display("FAIL basic_frame_cnt: got %0d, required 1", frame_cnt); end
  endtask

  task automatic test_twiddle();
    frame_t snap;
    out_ready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      send_beat(32'h0);
      send_beat(32'h0);
      send_beat(32'h0000_0100);
    end
    snap = data_par_out;
    checks++;
    for (int n = 0; n < 48; n++) begin
      if (snap[n] !== ((n % 6 == 4) ? 16'h0100 : 16'h0000)) begin
        errors++;
        $display("FAIL twiddle_word%0d: got %h, required %h", n, snap[n],
                 (n % 6 == 4) ? 16'h0100 : 16'h0000);
        break;
      end
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_backpressure();
    frame_t held;
    out_ready = 1'b0;
    for (int k = 0; k < 24; k++) send_beat($urandom);
    held = exp_q[0];
    in_valid = 1'b1;
    in_data = 32'hCAFE_BEEF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks += 2;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_c%0d: in_ready=%b out_valid=%b, required 0/1", c, in_ready, out_valid);
      end
      if (data_par_out !== held) begin
        errors++;
        $display("FAIL bp_data_c%0d: got %h, required %h", c, data_par_out, held);
      end
      step();
    end
    out_ready = 1'b1;
    send_beat(32'hCAFE_BEEF);
    checks++;
    if (data_par_out[1:0] !== {16'hCAFE, 16'hBEEF}) begin
      errors++;
      $display("FAIL bp_extra_beat: got %h, required cafebeef", data_par_out[1:0]);
    end
    for (int k = 1; k < 24; k++) send_beat($urandom);
    step();
  endtask

  task automatic test_gaps();
    out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      send_beat($urandom);
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data = $urandom;
        step();
      end
    end
    step();
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) send_beat($urandom | 32'h1);
    apply_reset();
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, required 0", out_valid); end
    if (data_par_out !== '0) begin errors++; $display("FAIL midrst_data: got %h, required 0", data_par_out); end
    if (frame_cnt !== 8'd0) begin errors++; $display("FAIL midrst_frame_cnt: got %0d, required 0", frame_cnt); end
    for (int k = 0; k < 24; k++) send_beat($urandom);
    step();
    checks++;
    if (frame_cnt !== 8'd1) begin errors++; $display("FAIL midrst_after: got %0d, required 1", frame_cnt); end
  endtask

`ifdef BUTTERFLY_LOADER_FLUSH_EN
  task automatic test_flush();
    logic [15:0] w12;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) send_beat($urandom);
    w12 = words_m[12];
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hDEAD_DEAD;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    k_m = 0;
    checks++;
    if (data_par_out[12] !== w12) begin errors++; $display("FAIL flush_word12: got %h, required %h", data_par_out[12], w12); end
    for (int k = 0; k < 24; k++) send_beat($urandom);
    step();
  endtask
`endif

  task automatic test_wrap();
    apply_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 256; f++)
      for (int k = 0; k < 24; k++) send_beat($urandom);
    step();
    step();
    checks += 2;
    if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_frame_cnt: got %0d, required 0", frame_cnt); end
    if (exp_fc !== 8'd0) begin errors++; $display("FAIL wrap_delivered: got %0d mod 256, required 0", exp_fc); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 32'h0;
    out_ready = 1'b1;
`ifdef BUTTERFLY_LOADER_FLUSH_EN
    flush = 1'b0;
`endif
    words_m = '0;
    k_m = 0;
    exp_fc = 8'd0;
    step();
    test_reset();
    test_basic_frame();
    test_twiddle();
    test_backpressure();
    test_gaps();
    test_mid_reset();
`ifdef BUTTERFLY_LOADER_FLUSH_EN
    test_flush();
`endif
    test_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_pending: got %0d undelivered, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
